// File: rtl/if_id_stage_if.sv
// if_id_stage_if: instruction-cache read port between the fetch stage (master) and the cache (slave).
interface if_id_stage_if;
  logic        ICACHE_ren;
  logic        ICACHE_wen;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  modport master (output ICACHE_ren, ICACHE_wen, ICACHE_addr, input ICACHE_rdata, ICACHE_stall);
  modport slave  (input ICACHE_ren, ICACHE_wen, ICACHE_addr, output ICACHE_rdata, ICACHE_stall);
endinterface

// File: rtl/if_id_stage.sv
// if_id_stage: instruction fetch + IF/ID register with a one-word skid buffer for ID stalls.
// Define IF_DELAY_SLOT_EN to keep the word completing alongside Flush_ID (MIPS delay slot).
module if_id_stage #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        rst_n,
  input  logic [31:0] PC,
  input  logic [31:0] PC_IF,
  input  logic        Stall_ID,
  input  logic        Flush_ID,
  if_id_stage_if.master ic,
  output logic        Stall,
  output logic [31:0] IR_ID,
  output logic [31:0] PC_ID,
  output logic        Valid_ID
);
  typedef enum logic {FETCH, BUF} state_t;
`ifdef IF_DELAY_SLOT_EN
  localparam bit DELAY_SLOT = 1'b1;
`else
  localparam bit DELAY_SLOT = 1'b0;
`endif
  state_t      state_q, state_d;
  logic [31:0] ir_q, ir_d, pcid_q, pcid_d, buf_ir_q, buf_ir_d, buf_pc_q, buf_pc_d;
  logic        valid_q, valid_d, squash;
  assign squash         = Flush_ID & ~DELAY_SLOT;
  assign ic.ICACHE_ren  = state_q == FETCH;
  assign ic.ICACHE_wen  = 1'b0;
  assign ic.ICACHE_addr = PC[31:2];
  assign Stall          = state_q == FETCH ? (ic.ICACHE_stall | Stall_ID) : Stall_ID;
  assign IR_ID          = ir_q;
  assign PC_ID          = pcid_q;
  assign Valid_ID       = valid_q;
  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    pcid_d   = pcid_q;
    valid_d  = valid_q;
    buf_ir_d = buf_ir_q;
    buf_pc_d = buf_pc_q;
    if (state_q == FETCH) begin
      if (!ic.ICACHE_stall) begin
        if (Stall_ID) begin
          state_d  = BUF;
          buf_ir_d = ic.ICACHE_rdata;
          buf_pc_d = PC_IF;
        end else begin
          ir_d    = squash ? NOP_WORD : ic.ICACHE_rdata;
          pcid_d  = squash ? 32'h0 : PC_IF;
          valid_d = ~squash;
        end
      end
    end else if (!Stall_ID) begin
      state_d = FETCH;
      ir_d    = squash ? NOP_WORD : buf_ir_q;
      pcid_d  = squash ? 32'h0 : buf_pc_q;
      valid_d = ~squash;
    end
  end
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      ir_q     <= NOP_WORD;
      pcid_q   <= '0;
      valid_q  <= 1'b0;
      buf_ir_q <= '0;
      buf_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_q     <= ir_d;
      pcid_q   <= pcid_d;
      valid_q  <= valid_d;
      buf_ir_q <= buf_ir_d;
      buf_pc_q <= buf_pc_d;
    end
  end
endmodule
